// File: rtl/refl_coeff_calc.sv
// Levinson-Durbin reflection-coefficient stage: serial MAC, rounding/clip check,
// 15-cycle restoring divide, then k^2 and prediction-error update.
module refl_coeff_calc #(
  parameter int ORDER = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         m,
  input  logic signed [31:0] r_0,
  input  logic signed [31:0] r_1,
  input  logic signed [31:0] r_2,
  input  logic signed [31:0] r_3,
  input  logic signed [31:0] r_4,
  input  logic signed [31:0] r_5,
  input  logic signed [31:0] r_6,
  input  logic signed [31:0] r_7,
  input  logic signed [31:0] r_8,
  input  logic signed [31:0] r_9,
  input  logic signed [31:0] r_10,
  input  logic signed [15:0] a_1,
  input  logic signed [15:0] a_2,
  input  logic signed [15:0] a_3,
  input  logic signed [15:0] a_4,
  input  logic signed [15:0] a_5,
  input  logic signed [15:0] a_6,
  input  logic signed [15:0] a_7,
  input  logic signed [15:0] a_8,
  input  logic signed [15:0] a_9,
  input  logic signed [15:0] a_10,
  input  logic signed [31:0] err,
  output logic signed [15:0] k,
  output logic signed [31:0] err_next,
  output logic               busy,
  output logic               vout,
  output logic               sat,
  output logic               div_err
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 48;
  localparam int NUM_W  = ACC_W - 15;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_ROUND, S_DIV, S_K2, S_ERRU
  } state_t;

  state_t r_state, w_state_nxt;

  logic        [3:0]        r_cnt;
  logic        [3:0]        r_m;
  logic signed [DATA_W-1:0] r_r [0:10];
  logic signed [COEF_W-1:0] r_a [0:10];
  logic signed [DATA_W-1:0] r_err;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_pos;
  logic        [31:0]       r_rem;
  logic        [13:0]       r_q;
  logic signed [COEF_W-1:0] r_kw;
  logic        [15:0]       r_k2;
  logic                     r_sat_w;
  logic                     r_derr_w;

  logic                     w_accept;
  logic                     w_ld, w_mac, w_rnd, w_div, w_div_last, w_k2, w_fin;
  logic signed [COEF_W-1:0] w_a_sel;
  logic signed [DATA_W-1:0] w_r_sel;
  logic signed [DATA_W-1:0] w_rm_sel;
  logic signed [ACC_W-1:0]  w_acc_init;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [NUM_W-1:0]  w_num;
  logic        [NUM_W-1:0]  w_mag;
  logic                     w_err_bad;
  logic                     w_clip;
  logic        [32:0]       w_rem_sh;
  logic                     w_ge;
  logic        [14:0]       w_q_nxt;
  logic signed [COEF_W-1:0] w_kmag;
  logic signed [ACC_W-1:0]  w_ksq_full;
  logic signed [ACC_W-1:0]  w_ep_full;

  // Q15 rounding of a 48-bit product/accumulator: add half an LSB, arithmetic shift
  function automatic logic signed [NUM_W-1:0] rnd_q15(input logic signed [ACC_W-1:0] x);
    return NUM_W'((x + 48'sd16384) >>> 15);
  endfunction

  // Clip value for |num| >= err: opposite sign of num, magnitude 32767
  function automatic logic signed [COEF_W-1:0] sat_k(input logic neg);
    return neg ? 16'sh7FFF : 16'sh8001;
  endfunction

  assign w_accept = start && (r_state == S_IDLE) && (m != 4'd0) && (int'(m) <= ORDER);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld || w_rnd)
        r_cnt <= 4'd0;
      else if (w_mac || w_div)
        r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (r_cnt == r_m - 4'd1) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = (w_err_bad || w_clip) ? S_K2 : S_DIV;
      S_DIV:   if (r_cnt == 4'd14) w_state_nxt = S_K2;
      S_K2:    w_state_nxt = S_ERRU;
      S_ERRU:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld       = w_accept;
    w_mac      = (r_state == S_MAC);
    w_rnd      = (r_state == S_ROUND);
    w_div      = (r_state == S_DIV);
    w_div_last = (r_state == S_DIV) && (r_cnt == 4'd14);
    w_k2       = (r_state == S_K2);
    w_fin      = (r_state == S_ERRU);
    busy       = (r_state != S_IDLE);
  end

  // MAC operands: cycle 0 loads r_m<<<15, cycle j adds a_j*r_{m-j}
  assign w_a_sel    = r_a[r_cnt];
  assign w_r_sel    = r_r[r_m - r_cnt];
  assign w_rm_sel   = r_r[r_m];
  assign w_acc_init = {w_rm_sel[31], w_rm_sel, 15'd0};
  assign w_prod     = {{32{w_a_sel[15]}}, w_a_sel} * {{16{w_r_sel[31]}}, w_r_sel};

  assign w_num     = rnd_q15(r_acc);
  assign w_mag     = w_num[NUM_W-1] ? NUM_W'(-w_num) : NUM_W'(w_num);
  assign w_err_bad = (r_err <= 32'sd0);
  assign w_clip    = (w_mag >= {1'b0, r_err});

  // mag < err, so the integer part of mag/err is zero and only 15 fraction bits remain
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_ge     = (w_rem_sh >= {1'b0, r_err});
  assign w_q_nxt  = {r_q, w_ge};
  assign w_kmag   = {1'b0, w_q_nxt};

  assign w_ksq_full = {{32{r_kw[15]}}, r_kw} * {{32{r_kw[15]}}, r_kw};
  assign w_ep_full  = {{16{r_err[31]}}, r_err} * {32'd0, r_k2};

  always_ff @(posedge clk) begin
    if (w_ld) begin
      r_m     <= m;
      r_err   <= err;
      r_r[0]  <= r_0;
      r_r[1]  <= r_1;
      r_r[2]  <= r_2;
      r_r[3]  <= r_3;
      r_r[4]  <= r_4;
      r_r[5]  <= r_5;
      r_r[6]  <= r_6;
      r_r[7]  <= r_7;
      r_r[8]  <= r_8;
      r_r[9]  <= r_9;
      r_r[10] <= r_10;
      r_a[0]  <= 16'sd0;
      r_a[1]  <= a_1;
      r_a[2]  <= a_2;
      r_a[3]  <= a_3;
      r_a[4]  <= a_4;
      r_a[5]  <= a_5;
      r_a[6]  <= a_6;
      r_a[7]  <= a_7;
      r_a[8]  <= a_8;
      r_a[9]  <= a_9;
      r_a[10] <= a_10;
    end
    if (w_mac)
      r_acc <= (r_cnt == 4'd0) ? w_acc_init : r_acc + w_prod;
    if (w_rnd) begin
      r_pos <= ~w_num[NUM_W-1] && (w_num != '0);
      r_rem <= w_mag[31:0];
      r_q   <= 14'd0;
      if (w_err_bad) begin
        r_kw     <= 16'sd0;
        r_sat_w  <= 1'b0;
        r_derr_w <= 1'b1;
      end else if (w_clip) begin
        r_kw     <= sat_k(w_num[NUM_W-1]);
        r_sat_w  <= 1'b1;
        r_derr_w <= 1'b0;
      end else begin
        r_sat_w  <= 1'b0;
        r_derr_w <= 1'b0;
      end
    end
    if (w_div) begin
      r_rem <= 32'(w_ge ? w_rem_sh - {1'b0, r_err} : w_rem_sh);
      r_q   <= w_q_nxt[13:0];
      if (w_div_last)
        r_kw <= r_pos ? -w_kmag : w_kmag;
    end
    if (w_k2)
      r_k2 <= 16'(rnd_q15(w_ksq_full));
  end

  // Visible results change only together with vout
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= 16'sd0;
      err_next <= 32'sd0;
      sat      <= 1'b0;
      div_err  <= 1'b0;
      vout     <= 1'b0;
    end else begin
      vout <= w_fin;
      if (w_fin) begin
        k        <= r_kw;
        err_next <= 32'(33'(r_err) - rnd_q15(w_ep_full));
        sat      <= r_sat_w;
        div_err  <= r_derr_w;
      end
    end
  end

endmodule

// File: tb/tb_refl_coeff_calc.sv
// Bench for refl_coeff_calc: directed vector table, random ops against an
// arithmetic model, and hand sequences for ignored starts and mid-op reset.
module tb_refl_coeff_calc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [3:0]         m = 4'd0;
  logic signed [31:0] rr [0:10];
  logic signed [15:0] aa [1:10];
  logic signed [31:0] err_in = 32'sd0;
  logic signed [15:0] k;
  logic signed [31:0] err_next;
  logic               busy, vout, sat, div_err;

  int n_chk  = 0;
  int n_fail = 0;
  int tag    = 0;

  refl_coeff_calc #(.ORDER(10)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m),
    .r_0(rr[0]), .r_1(rr[1]), .r_2(rr[2]), .r_3(rr[3]), .r_4(rr[4]), .r_5(rr[5]),
    .r_6(rr[6]), .r_7(rr[7]), .r_8(rr[8]), .r_9(rr[9]), .r_10(rr[10]),
    .a_1(aa[1]), .a_2(aa[2]), .a_3(aa[3]), .a_4(aa[4]), .a_5(aa[5]),
    .a_6(aa[6]), .a_7(aa[7]), .a_8(aa[8]), .a_9(aa[9]), .a_10(aa[10]),
    .err(err_in), .k(k), .err_next(err_next), .busy(busy), .vout(vout),
    .sat(sat), .div_err(div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int r0, r1, r2;
    int a1;
    int e;
    int ek, een;
    bit es, ed;
    int lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [case %0d]: got %0d, expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i <= 10; i++) rr[i] = 32'sd0;
    for (int i = 1; i <= 10; i++) aa[i] = 16'sd0;
  endtask

  // Reference: direct evaluation of the recursion formulas with 64-bit integers
  function automatic void model(input int mm, output longint ek, output longint een,
                                output longint es, output longint ed, output int elat);
    longint acc, num, mag, q, k2, e, kk;
    e   = longint'(err_in);
    acc = longint'(rr[mm]) * 32768;
    for (int j = 1; j < mm; j++) acc += longint'(aa[j]) * longint'(rr[mm - j]);
    num = (acc + 16384) >>> 15;
    mag = (num < 0) ? -num : num;
    es = 0; ed = 0;
    if (e <= 0) begin
      kk = 0; ed = 1; elat = mm + 3;
    end else if (mag >= e) begin
      kk = (num > 0) ? -32767 : 32767; es = 1; elat = mm + 3;
    end else begin
      q = (mag * 32768) / e;
      kk = (num > 0) ? -q : q; elat = mm + 18;
    end
    k2  = (kk * kk + 16384) >>> 15;
    ek  = kk;
    een = longint'(int'(e - ((e * k2 + 16384) >>> 15)));
  endfunction

  task automatic drive_start(input int mm);
    @(negedge clk);
    m = 4'(mm);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input int mm, output longint gk, output longint gen,
                        output longint gs, output longint gd, output int glat);
    glat = -1;
    gk = 0; gen = 0; gs = 0; gd = 0;
    drive_start(mm);
    chk("busy_after_start", busy, 1);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (vout) begin
        glat = c;
        break;
      end
    end
    if (glat < 0) begin
      chk("vout_timeout", 0, 1);
    end else begin
      gk = k; gen = err_next; gs = sat; gd = div_err;
      chk("busy_at_vout", busy, 0);
      @(posedge clk);
      #1;
      chk("vout_one_cycle", vout, 0);
    end
  endtask

  task automatic check_op(input int mm, input longint ek, input longint een,
                          input longint es, input longint ed, input int elat);
    longint gk, gen, gs, gd;
    int glat;
    run_op(mm, gk, gen, gs, gd, glat);
    chk("latency", glat, elat);
    chk("k", gk, ek);
    chk("err_next", gen, een);
    chk("sat", gs, es);
    chk("div_err", gd, ed);
  endtask

  initial begin
    longint ek, een, es, ed;
    int elat, nv, glat, sel, nb;
    longint gk, gen;

    clear_inputs();
    tbl[0] = '{1, 1000, 500,    0,      0, 1000, -16384, 750, 1'b0, 1'b0, 19};
    tbl[1] = '{2, 1000, 500,  300, -16384,  750,  -2184, 747, 1'b0, 1'b0, 20};
    tbl[2] = '{1, 1000, 2000,   0,      0, 1000, -32767,   0, 1'b1, 1'b0,  4};
    tbl[3] = '{1, 1000, -500,   0,      0, 1000,  16384, 750, 1'b0, 1'b0, 19};
    tbl[4] = '{1, 1000, -500,   0,      0,    0,      0,   0, 1'b0, 1'b1,  4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_k", k, 0);
    chk("rst_err_next", err_next, 0);
    chk("rst_sat", sat, 0);
    chk("rst_div_err", div_err, 0);
    chk("rst_vout", vout, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      tag = 100 + i;
      clear_inputs();
      rr[0] = 32'(tbl[i].r0);
      rr[1] = 32'(tbl[i].r1);
      rr[2] = 32'(tbl[i].r2);
      aa[1] = 16'(tbl[i].a1);
      err_in = 32'(tbl[i].e);
      check_op(tbl[i].m, tbl[i].ek, tbl[i].een, tbl[i].es, tbl[i].ed, tbl[i].lat);
    end

    // Random operations against the model
    for (int t = 0; t < 40; t++) begin
      int mm;
      tag = 200 + t;
      mm = int'($urandom_range(1, 10));
      for (int i = 0; i <= 10; i++) rr[i] = 32'(int'($urandom_range(0, 2097152)) - 1048576);
      for (int i = 1; i <= 10; i++) aa[i] = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      err_in = -32'(int'($urandom_range(0, 5000)));
      else if (sel == 1) err_in = 32'(int'($urandom_range(1, 2000)));
      else               err_in = 32'(int'($urandom_range(1, 16777216)));
      model(mm, ek, een, es, ed, elat);
      check_op(mm, ek, een, es, ed, elat);
    end

    // start during DIV is ignored: one vout with the first request's results
    tag = 300;
    clear_inputs();
    rr[1] = 32'sd200; rr[2] = 32'sd300; rr[3] = 32'sd500;
    aa[1] = -16'sd8000; aa[2] = 16'sd4000;
    err_in = 32'sd5000;
    model(3, ek, een, es, ed, elat);
    drive_start(3);
    nv = 0; glat = -1; gk = 0; gen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (vout) begin
        nv++;
        if (glat < 0) begin
          glat = c; gk = k; gen = err_next;
        end
      end
      if (c == 8) begin
        m = 4'd1; rr[1] = 32'sd9999; err_in = 32'sd3;
        start = 1'b1;
      end
    end
    chk("middiv_vout_count", nv, 1);
    chk("middiv_latency", glat, elat);
    chk("middiv_k", gk, ek);
    chk("middiv_err_next", gen, een);

    // Out-of-range orders are ignored and outputs hold
    for (int t = 0; t < 2; t++) begin
      tag = 310 + t;
      drive_start(t == 0 ? 0 : 11);
      nv = 0; nb = 0;
      chk("badm_busy", busy, 0);
      repeat (30) begin
        @(posedge clk);
        #1;
        if (vout) nv++;
        if (busy) nb++;
      end
      chk("badm_vout_count", nv, 0);
      chk("badm_busy_count", nb, 0);
      chk("badm_k_hold", k, ek);
      chk("badm_err_next_hold", err_next, een);
    end

    // Reset in the middle of MAC aborts and clears outputs
    tag = 320;
    clear_inputs();
    for (int i = 1; i <= 5; i++) rr[i] = 32'(i * 100);
    err_in = 32'sd50000;
    drive_start(5);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_k", k, 0);
    chk("midrst_err_next", err_next, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_div_err", div_err, 0);
    chk("midrst_vout", vout, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (vout) nv++;
    end
    chk("midrst_vout_count", nv, 0);

    tag = 330;
    clear_inputs();
    rr[0] = 32'sd1000; rr[1] = 32'sd500; err_in = 32'sd1000;
    check_op(1, -16384, 750, 0, 0, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout [case %0d]: got 1, expected 0", tag);
    $fatal(1, "timeout");
  end

endmodule
